// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width, and the
// default bit time used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// high so the line reads as idle coming out of reset.
module uart_sync2 (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, sampling each bit at its midpoint.
//
// state | meaning
// IDLE  | line high, waiting for a start-bit low level
// START | timing half a bit to confirm the start bit at its midpoint
// DATA  | sampling 8 data bits, one per bit time
// STOP  | timing to mid-stop-bit, then loading the byte and flags
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rxD,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rdrf,
    output logic       ferr,
    output logic       oerr
);

    localparam logic [15:0] HALF_TC  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_TC   = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          state;
    logic [15:0]          baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rxs;
    logic                 frame_done;

    uart_sync2 u_sync (
        .clk (clk),
        .clr (clr),
        .d   (rxD),
        .q   (rxs)
    );

    assign frame_done = (state == STOP) && (baud_cnt == BIT_TC);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rdrf      <= 1'b0;
            ferr      <= 1'b0;
            oerr      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_TC) begin
                        baud_cnt <= '0;
                        // A high level at mid-start is a glitch, not a frame
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_TC) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_TC) begin
                        baud_cnt <= '0;
                        rx_data  <= shift_reg;
                        ferr     <= ~rxs;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A read in the load cycle consumes the old byte, so the new one
            // stays pending without an overrun.
            if (frame_done) begin
                rdrf <= 1'b1;
                if (rdrf && !rd) begin
                    oerr <= 1'b1;
                end else if (rd) begin
                    oerr <= 1'b0;
                end
            end else if (rd && rdrf) begin
                rdrf <= 1'b0;
                oerr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model with
// directed scenarios and randomized frames, glitches and read strobes.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int C   = 16;
    localparam int H   = C / 2;
    localparam int LAT = 2 + H + 9 * C + 1;

    logic       clk, clr, rxD, rd;
    logic [7:0] rx_data;
    logic       rdrf, ferr, oerr;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk     (clk),
        .clr     (clr),
        .rxD     (rxD),
        .rd      (rd),
        .rx_data (rx_data),
        .rdrf    (rdrf),
        .ferr    (ferr),
        .oerr    (oerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] b;
        logic       fe;
    } load_t;

    load_t      loads[$];
    int         cyc = 0;
    int         tests = 0;
    int         errors = 0;
    int         last_rise = -1;
    logic       prev_rdrf = 1'b0;
    logic       rd_rand_en = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_rdrf = 1'b0, m_ferr = 1'b0, m_oerr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a frame whose falling edge is at cycle t completes at t+LAT.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!clr) begin
                m_data = 8'h00; m_rdrf = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
                loads.delete();
            end else if (loads.size() > 0 && loads[0].cyc == cyc) begin
                load_t e;
                e = loads.pop_front();
                if (m_rdrf && !rd) m_oerr = 1'b1;
                else if (rd) m_oerr = 1'b0;
                m_data = e.b;
                m_ferr = e.fe;
                m_rdrf = 1'b1;
            end else if (rd && m_rdrf) begin
                m_rdrf = 1'b0;
                m_oerr = 1'b0;
            end
            #1;
            check($sformatf("cycle%0d", cyc), {21'd0, rx_data, rdrf, ferr, oerr},
                  {21'd0, m_data, m_rdrf, m_ferr, m_oerr});
            if (rdrf && !prev_rdrf) last_rise = cyc;
            prev_rdrf = rdrf;
        end
    end

    always @(negedge clk) begin
        if (rd_rand_en) rd = ($urandom_range(0, 99) < 3);
    end

    task automatic drive(input logic v);
        rxD = v;
        repeat (C) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; plays the role of the transmitter.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
        load_t e;
        t0 = cyc;
        e.cyc = cyc + LAT; e.b = b; e.fe = ~stop;
        loads.push_back(e);
        drive(1'b0);
        for (int i = 0; i < 8; i++) drive(b[i]);
        drive(stop);
        rxD = 1'b1;
    endtask

    task automatic read_pulse();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] d, input logic f, input logic fe, input logic oe);
        check({tag, "_data"}, 32'(rx_data), 32'(d));
        check({tag, "_rdrf"}, 32'(rdrf), 32'(f));
        check({tag, "_ferr"}, 32'(ferr), 32'(fe));
        check({tag, "_oerr"}, 32'(oerr), 32'(oe));
    endtask

    int t0, t1, base;
    logic [7:0] lb[3];

    initial begin
        rxD = 1'b1; rd = 1'b0; clr = 1'b0;
        #2;
        check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        idle(5);

        send_frame(8'hA5, 1'b1, t0);
        idle(4);
        check("latency", 32'(last_rise - t0), 32'd155);
        check_outs("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        read_pulse();
        idle(2);

        rxD = 1'b0;
        idle(4);
        rxD = 1'b1;
        idle(40);
        check_outs("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);
        check("glitch_state", 32'(dut.state), 32'(IDLE));

        send_frame(8'h3C, 1'b0, t0);
        idle(2 * C);
        check_outs("ferr", 8'h3C, 1'b1, 1'b1, 1'b0);
        read_pulse();
        send_frame(8'h01, 1'b1, t0);
        idle(4);
        check_outs("ferr_clr", 8'h01, 1'b1, 1'b0, 1'b0);
        read_pulse();
        idle(2);

        send_frame(8'h11, 1'b1, t0);
        send_frame(8'h22, 1'b1, t1);
        idle(4);
        check_outs("overrun", 8'h22, 1'b1, 1'b0, 1'b1);
        read_pulse();
        check_outs("ovr_read", 8'h22, 1'b0, 1'b0, 1'b0);

        base = cyc;
        fork
            begin
                send_frame(8'h11, 1'b1, t0);
                send_frame(8'h22, 1'b1, t1);
            end
            begin
                repeat (2 * LAT + 5 - 1 - 0) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        idle(4);
        check("coinc_base", 32'(t1 - base), 32'd160);
        check_outs("coinc", 8'h22, 1'b1, 1'b0, 1'b0);

        drive(1'b0);
        drive(1'b0);
        drive(1'b1);
        drive(1'b1);
        rxD = 1'b1;
        idle(H);
        clr = 1'b0;
        #1;
        check_outs("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        idle(3);
        clr = 1'b1;
        idle(5);
        check_outs("rst_rel", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, t0);
        idle(4);
        check_outs("post_rst", 8'h81, 1'b1, 1'b0, 1'b0);
        read_pulse();

        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            send_frame(lb[i], 1'b1, t0);
            idle(4);
            check_outs($sformatf("loop%0d", i), lb[i], 1'b1, 1'b0, 1'b0);
            read_pulse();
        end

        rd_rand_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                rxD = 1'b0;
                idle($urandom_range(1, 5));
                rxD = 1'b1;
                idle(2 * C + $urandom_range(0, 10));
            end else begin
                logic stop;
                stop = (kind != 1);
                send_frame(8'($urandom_range(0, 255)), stop, t0);
                if (stop) idle($urandom_range(0, 20));
                else idle(2 * C + $urandom_range(0, 10));
            end
        end
        rd_rand_en = 1'b0;
        rd = 1'b0;
        idle(LAT + 20);
        check("queue_drained", 32'(loads.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
